// File: rtl/sram_pkg.sv
// Shared FSM state encoding, requester indices and round-robin helper for the SPRAM scheduler.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WRITE        = 2'd1,
        READ_ADDR    = 2'd2,
        READ_CAPTURE = 2'd3
    } state_t;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_W  = 2'd0;
    localparam req_idx_t REQ_R1 = 2'd1;
    localparam req_idx_t REQ_R2 = 2'd2;

    localparam int unsigned NUM_REQ = 3;

    // Next requester in the fixed W -> R1 -> R2 -> W rotation.
    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == REQ_R2) ? REQ_W : req_idx_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/sram_write_fifo.sv
// Synchronous write queue holding {address, data} entries; pointers wrap modulo DEPTH.
module sram_write_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_c,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    // A pop frees the slot being written, so a full queue still accepts a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_c  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Entry storage; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_scheduler.sv
// Arbitrates one queued write port and two read ports onto a single-port SRAM.
module sram_scheduler
    import sram_pkg::*;
#(
    parameter int unsigned ADDRESS_BUS_WIDTH = 14,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned WRITE_FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDRESS_BUS_WIDTH-1:0] write_address,
    input  logic [DATA_BUS_WIDTH-1:0]    write_data,
    input  logic                         write_strobe,
    output logic                         write_full,
    input  logic [ADDRESS_BUS_WIDTH-1:0] read_address_1,
    input  logic [ADDRESS_BUS_WIDTH-1:0] read_address_2,
    input  logic                         read_strobe_1,
    input  logic                         read_strobe_2,
    output logic                         read_finished_strobe_1,
    output logic                         read_finished_strobe_2,
    output logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic [ADDRESS_BUS_WIDTH-1:0] ram_address,
    output logic [DATA_BUS_WIDTH-1:0]    ram_data_in,
    output logic                         ram_wren,
    input  logic [DATA_BUS_WIDTH-1:0]    ram_data_out,
    output logic                         overflow
);

    localparam int unsigned ENTRY_W = ADDRESS_BUS_WIDTH + DATA_BUS_WIDTH;
    localparam int unsigned CNT_W   = $clog2(WRITE_FIFO_DEPTH) + 1;

    state_t                       state;
    req_idx_t                     last_grant;
    logic                         pending_1;
    logic                         pending_2;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_1;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_2;
    logic                         read_port;

    logic [ENTRY_W-1:0]           fifo_head;
    logic [CNT_W-1:0]             fifo_count;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         write_drop;

    logic [NUM_REQ-1:0]           req;
    req_idx_t                     cand_1;
    req_idx_t                     cand_2;
    req_idx_t                     cand_3;
    req_idx_t                     grant;
    logic                         grant_valid;

    // Round-robin pick among W/R1/R2, starting just after the last winner; only IDLE grants.
    always_comb begin
        req         = {pending_2, pending_1, !fifo_empty};
        cand_1      = rr_next(last_grant);
        cand_2      = rr_next(cand_1);
        cand_3      = rr_next(cand_2);
        grant       = cand_1;
        grant_valid = 1'b0;
        if (state == IDLE) begin
            if (req[cand_1]) begin
                grant       = cand_1;
                grant_valid = 1'b1;
            end else if (req[cand_2]) begin
                grant       = cand_2;
                grant_valid = 1'b1;
            end else if (req[cand_3]) begin
                grant       = cand_3;
                grant_valid = 1'b1;
            end
        end
    end

    // Queue admission: a full queue only takes a write when the head leaves this cycle.
    assign fifo_pop   = grant_valid && (grant == REQ_W);
    assign fifo_push  = write_strobe && ((fifo_count != CNT_W'(WRITE_FIFO_DEPTH)) || fifo_pop);
    assign write_drop = write_strobe && !fifo_push;

    sram_write_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WRITE_FIFO_DEPTH)
    ) u_write_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({write_address, write_data}),
        .pop       (fifo_pop),
        .head_c    (fifo_head),
        .count     (fifo_count),
        .full      (write_full),
        .empty     (fifo_empty)
    );

    // Scheduler FSM with read-request latches and all registered SRAM/user outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            last_grant             <= REQ_R2;
            pending_1              <= 1'b0;
            pending_2              <= 1'b0;
            addr_1                 <= '0;
            addr_2                 <= '0;
            read_port              <= 1'b0;
            ram_address            <= '0;
            ram_data_in            <= '0;
            ram_wren               <= 1'b0;
            read_data              <= '0;
            read_finished_strobe_1 <= 1'b0;
            read_finished_strobe_2 <= 1'b0;
            overflow               <= 1'b0;
        end else begin
            ram_wren               <= 1'b0;
            read_finished_strobe_1 <= 1'b0;
            read_finished_strobe_2 <= 1'b0;

            if (write_drop) overflow <= 1'b1;

            if (read_strobe_1 && !pending_1) begin
                pending_1 <= 1'b1;
                addr_1    <= read_address_1;
            end
            if (read_strobe_2 && !pending_2) begin
                pending_2 <= 1'b1;
                addr_2    <= read_address_2;
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        last_grant <= grant;
                        case (grant)
                            REQ_W: begin
                                ram_address <= fifo_head[ENTRY_W-1:DATA_BUS_WIDTH];
                                ram_data_in <= fifo_head[DATA_BUS_WIDTH-1:0];
                                ram_wren    <= 1'b1;
                                state       <= WRITE;
                            end
                            REQ_R1: begin
                                ram_address <= addr_1;
                                pending_1   <= 1'b0;
                                read_port   <= 1'b0;
                                state       <= READ_ADDR;
                            end
                            REQ_R2: begin
                                ram_address <= addr_2;
                                pending_2   <= 1'b0;
                                read_port   <= 1'b1;
                                state       <= READ_ADDR;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                WRITE:     state <= IDLE;
                READ_ADDR: state <= READ_CAPTURE;
                READ_CAPTURE: begin
                    read_data <= ram_data_out;
                    if (read_port) read_finished_strobe_2 <= 1'b1;
                    else           read_finished_strobe_1 <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_scheduler.md
SRAM_SCHEDULER -- requirements
Module: sram_scheduler

Interface
REQ-001 The block SHALL have parameter ADDRESS_BUS_WIDTH, default 14, SPRAM word address width.
REQ-002 The block SHALL have parameter DATA_BUS_WIDTH, default 16, SPRAM word width.
REQ-003 The block SHALL have parameter WRITE_FIFO_DEPTH, default 4, write queue entries (power of two, 2 or more).
REQ-004 The block SHALL have a single clock and an asynchronous active-low reset, with these ports:
  clk  in  1  clock; all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  write_address  in  ADDRESS_BUS_WIDTH  write word address
  write_data  in  DATA_BUS_WIDTH  write word
  write_strobe  in  1  one-cycle write request
  write_full  out  1  write queue full
  read_address_1 / read_address_2  in  ADDRESS_BUS_WIDTH  read port addresses
  read_strobe_1 / read_strobe_2  in  1  one-cycle read requests
  read_finished_strobe_1 / read_finished_strobe_2  out  1  one-cycle read done
  read_data  out  DATA_BUS_WIDTH  last read word (shared by both ports)
  ram_address  out  ADDRESS_BUS_WIDTH  to SPRAM ADDRESS
  ram_data_in  out  DATA_BUS_WIDTH  to SPRAM DATAIN
  ram_wren  out  1  to SPRAM WREN
  ram_data_out  in  DATA_BUS_WIDTH  from SPRAM DATAOUT
  overflow  out  1  sticky: write dropped while full

Function
REQ-005 A write_strobe SHALL push {write_address, write_data} into the write FIFO at the next edge unless write_full is high; if full, the write SHALL be dropped and overflow set.
REQ-006 A read_strobe_k SHALL latch read_address_k and set pending_k at the next edge; a strobe while pending_k is set SHALL be ignored (address unchanged).
REQ-007 The FSM SHALL have states IDLE, WRITE, READ_ADDR, READ_CAPTURE.
REQ-008 In IDLE, request set = {FIFO non-empty, pending_1, pending_2}; on any request, one grant SHALL be issued, round-robin in order W, R1, R2, starting after the last granted requester (W first after reset).
REQ-009 Write grant: ram_address/ram_data_in SHALL be loaded from the FIFO head, the entry popped, ram_wren set to 1, and the next state SHALL be WRITE.
REQ-010 In WRITE, ram_wren SHALL be high for exactly that one cycle, and the next state SHALL be IDLE.
REQ-011 Read grant: ram_address SHALL be loaded with the latched address, pending_k cleared, and the next state READ_ADDR, followed by READ_CAPTURE.
REQ-012 In READ_CAPTURE, read_data SHALL be loaded from ram_data_out, read_finished_strobe_k pulsed for one cycle, and the next state SHALL be IDLE.
REQ-013 Latency on an idle bus: a read strobe in cycle 0 SHALL produce read_finished_strobe_k and valid read_data in cycle 4; a write strobe in cycle 0 SHALL produce ram_wren high in cycle 2.
REQ-014 A read_strobe_k arriving in the same cycle its finished strobe is high SHALL be accepted as a new request.
REQ-015 A push and a pop on the FIFO in the same cycle SHALL both occur; the count SHALL be unchanged; full state SHALL not block that push.
REQ-016 write_full SHALL be high when the count equals WRITE_FIFO_DEPTH; FIFO pointers SHALL wrap modulo depth.
REQ-017 No read/write ordering or forwarding SHALL be provided; ordering is by arbitration only.
REQ-018 ram_wren SHALL be 0 in every state except WRITE.

Reset
REQ-019 On rst_n low, asynchronously: state=IDLE; FIFO empty; pending_1/2=0; RR pointer set so W has first priority; ram_address, ram_data_in, read_data=0; ram_wren, read_finished_strobe_1/2, write_full, overflow=0.
REQ-020 Reset mid-operation SHALL abort any in-flight access with no finished strobe, and queued writes SHALL be discarded.

Structure
REQ-021 Package sram_pkg SHALL hold the FSM state encodings and requester index constants (REQ_W, REQ_R1, REQ_R2).
REQ-022 The write queue SHALL be a sub-module sram_write_fifo (synchronous FIFO with count, full, and empty outputs); arbitration and the FSM SHALL stay in sram_scheduler.

Verification
REQ-023 Write 0xBEEF @0x0010, then read port 1 @0x0010 -> ram_wren pulses once with address 0x0010; finished_1 is asserted and read_data=0xBEEF.
REQ-024 read_strobe_1 @0x20 and read_strobe_2 @0x30 in the same cycle, with a write queued -> grants occur in order W, R1, R2; each finished strobe appears once.
REQ-025 Five write strobes on consecutive cycles while port 1 reads continuously (depth 4) -> write_full rises; at most one write is dropped; overflow=1 only if one is dropped.
REQ-026 read_strobe_2 repeated with a new address while pending -> the original address is used; one finished_2 is produced.
REQ-027 rst_n low during READ_ADDR -> no finished strobe; all outputs are at reset values; the FIFO is empty.
REQ-028 Randomized strobes for 10k cycles against a memory model -> every read returns the model value at grant time; there is no starvation (every request is granted within 3 grants).
